// File: rtl/async_oneway_transmitter.sv
`default_nettype none

`ifndef MESSAGE_SIZE
`define MESSAGE_SIZE 14
`endif

// ============================================================================
// Module   : async_oneway_transmitter
// Function : Serialises a message into 6-bit chunks with slow, debouncer-safe
//            chunk and commit strobes for the one-way board-to-board link.
// Revision : 1.0
// ============================================================================
module async_oneway_transmitter #(
    parameter int MSG_W       = `MESSAGE_SIZE,
    parameter int HOLD_CYCLES = 16
) (
    input  logic             clk_send,
    input  logic             rst_n,
    input  logic             send,
    input  logic [MSG_W-1:0] message,
    output logic             busy,
    output logic             done,
    output logic [5:0]       dout,
    output logic             packet_pulse,
    output logic             transmit_ctrl
);

    localparam int N_CHUNKS = MSG_W / 6 + 1;
    localparam int FRAME_W  = 6 * N_CHUNKS;
    localparam int PAD_W    = FRAME_W - MSG_W;
    localparam int CNT_W    = $clog2(HOLD_CYCLES);
    localparam int IDX_W    = $clog2(N_CHUNKS + 1);

    localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] C_IDX_LAST  = IDX_W'(N_CHUNKS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        STROBE   = 3'd2,
        RELEASE  = 3'd3,
        COMMIT   = 3'd4,
        COOLDOWN = 3'd5
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [FRAME_W-1:0] r_shift;

    logic [FRAME_W-1:0] w_frame;
    logic [FRAME_W-1:0] w_shifted;
    logic               w_hold_done;

    // Padding always lands in the last chunk so the far end's window lines up.
    assign w_frame     = {{PAD_W{1'b0}}, message};
    assign w_shifted   = r_shift >> 6;
    assign w_hold_done = (r_cnt == C_HOLD_LAST);

    always_ff @(posedge clk_send or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_shift       <= '0;
            dout          <= 6'd0;
            packet_pulse  <= 1'b0;
            transmit_ctrl <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (send) begin
                        r_shift <= w_frame;
                        dout    <= w_frame[5:0];
                        r_idx   <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    if (w_hold_done) begin
                        r_cnt        <= '0;
                        packet_pulse <= 1'b1;
                        r_state      <= STROBE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STROBE: begin
                    if (w_hold_done) begin
                        r_cnt        <= '0;
                        packet_pulse <= 1'b0;
                        r_state      <= RELEASE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (w_hold_done) begin
                        r_cnt <= '0;
                        if (r_idx == C_IDX_LAST) begin
                            transmit_ctrl <= 1'b1;
                            r_state       <= COMMIT;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_shift <= w_shifted;
                            dout    <= w_shifted[5:0];
                            r_state <= SETUP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                COMMIT: begin
                    if (w_hold_done) begin
                        r_cnt         <= '0;
                        transmit_ctrl <= 1'b0;
                        r_state       <= COOLDOWN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                COOLDOWN: begin
                    if (w_hold_done) begin
                        r_cnt   <= '0;
                        dout    <= 6'd0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_async_oneway_transmitter.sv
`default_nettype none

// ============================================================================
// Module   : tb_async_oneway_transmitter
// Function : Self-checking bench for async_oneway_transmitter using a loopback
//            receiver model and frame timing derived from the link rules.
// Revision : 1.0
// ============================================================================
module tb_async_oneway_transmitter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        send_w  [3];
    logic [13:0] msg_a;
    logic [11:0] msg_b;
    logic [13:0] msg_c;
    logic [5:0]  dout_w  [3];
    logic        pp_w    [3];
    logic        tc_w    [3];
    logic        busy_w  [3];
    logic        done_w  [3];

    always #5 clk = ~clk;

    async_oneway_transmitter #(.MSG_W(14), .HOLD_CYCLES(4)) u_a (
        .clk_send(clk), .rst_n(rst_n), .send(send_w[0]), .message(msg_a),
        .busy(busy_w[0]), .done(done_w[0]), .dout(dout_w[0]),
        .packet_pulse(pp_w[0]), .transmit_ctrl(tc_w[0]));

    async_oneway_transmitter #(.MSG_W(12), .HOLD_CYCLES(4)) u_b (
        .clk_send(clk), .rst_n(rst_n), .send(send_w[1]), .message(msg_b),
        .busy(busy_w[1]), .done(done_w[1]), .dout(dout_w[1]),
        .packet_pulse(pp_w[1]), .transmit_ctrl(tc_w[1]));

    async_oneway_transmitter #(.MSG_W(14), .HOLD_CYCLES(2)) u_c (
        .clk_send(clk), .rst_n(rst_n), .send(send_w[2]), .message(msg_c),
        .busy(busy_w[2]), .done(done_w[2]), .dout(dout_w[2]),
        .packet_pulse(pp_w[2]), .transmit_ctrl(tc_w[2]));

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int sel        = 0;

    int pp_t[$];
    int ch_q[$];
    int tcr_t[$];
    int tcf_t[$];
    int done_t[$];
    int pub_q[$];
    int busy_cnt  = 0;
    int unstable  = 0;

    logic        pp_prev   [3] = '{default: 1'b0};
    logic        tc_prev   [3] = '{default: 1'b0};
    logic [5:0]  dout_prev [3] = '{default: 6'd0};
    logic [19:0] rx        [3] = '{default: 20'd0};

    function automatic int mw(input int i);
        return (i == 1) ? 12 : 14;
    endfunction

    function automatic int hold(input int i);
        return (i == 2) ? 2 : 4;
    endfunction

    function automatic int qget(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Event log and loopback receiver: shifts chunks in at the MSB end of an
    // (MSG_W+6)-bit register and publishes its window on the commit strobe.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (pp_w[i] && !pp_prev[i])
                rx[i] = (rx[i] >> 6) | (20'(dout_w[i]) << mw(i));
            if (i == sel) begin
                if (pp_w[i] && !pp_prev[i]) begin
                    pp_t.push_back(cyc);
                    ch_q.push_back(int'(dout_w[i]));
                end
                if (tc_w[i] && !tc_prev[i]) begin
                    tcr_t.push_back(cyc);
                    pub_q.push_back(int'((rx[i] >> (mw(i) % 6)) & ((20'd1 << mw(i)) - 20'd1)));
                end
                if (!tc_w[i] && tc_prev[i]) tcf_t.push_back(cyc);
                if (done_w[i]) done_t.push_back(cyc);
                if (busy_w[i]) busy_cnt++;
                if ((pp_w[i] || tc_w[i]) && dout_w[i] !== dout_prev[i]) unstable++;
            end
            pp_prev[i]   = pp_w[i];
            tc_prev[i]   = tc_w[i];
            dout_prev[i] = dout_w[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        pp_t.delete(); ch_q.delete(); tcr_t.delete(); tcf_t.delete();
        done_t.delete(); pub_q.delete();
        busy_cnt = 0;
        unstable = 0;
    endtask

    task automatic set_msg(input int i, input logic [13:0] m);
        case (i)
            0: msg_a = m;
            1: msg_b = m[11:0];
            default: msg_c = m;
        endcase
    endtask

    // Caller is positioned just after a falling edge; accept lands on the next rising edge.
    task automatic start_frame(input int i, input logic [13:0] m, output int t0);
        set_msg(i, m);
        send_w[i] = 1'b1;
        t0 = cyc + 1;
        @(negedge clk); #1;
        send_w[i] = 1'b0;
    endtask

    task automatic wait_done(input int n);
        for (int c = 0; c < 400 && done_t.size() < n; c++) begin
            @(negedge clk); #1;
        end
        chk("done_seen", 32'(done_t.size() >= n), 32'd1);
    endtask

    task automatic check_frame(input int i, input logic [13:0] m, input int t0, input int f);
        int n;
        int h;
        n = mw(i) / 6 + 1;
        h = hold(i);
        for (int k = 0; k < n; k++) begin
            chk("chunk", qget(ch_q, f * n + k), (int'(m) >> (6 * k)) & 63);
            chk("pp_rise", qget(pp_t, f * n + k), t0 + h * (3 * k + 1));
        end
        chk("tc_rise", qget(tcr_t, f), t0 + 3 * n * h);
        chk("tc_fall", qget(tcf_t, f), t0 + (3 * n + 1) * h);
        chk("done_at", qget(done_t, f), t0 + (3 * n + 2) * h);
        chk("publish", qget(pub_q, f), int'(m));
    endtask

    task automatic run_single(input int i, input logic [13:0] m);
        int t0;
        sel = i;
        clear_logs();
        start_frame(i, m, t0);
        wait_done(1);
        repeat (4) @(negedge clk);
        #1;
        check_frame(i, m, t0, 0);
        chk("busy_cycles", busy_cnt, (3 * (mw(i) / 6 + 1) + 2) * hold(i));
        chk("dout_stable", unstable, 0);
    endtask

    initial begin
        int t0;
        logic [13:0] r;

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) send_w[i] = 1'b0;
        msg_a = '0; msg_b = '0; msg_c = '0;
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_dout", dout_w[i], 0);
            chk("rst_pp", pp_w[i], 0);
            chk("rst_tc", tc_w[i], 0);
            chk("rst_busy", busy_w[i], 0);
            chk("rst_done", done_w[i], 0);
        end
        rst_n = 1'b1;
        @(negedge clk); #1;

        // Reference 14-bit frame and the all-ones 12-bit frame with zero padding chunk.
        run_single(0, 14'h2A5C);
        run_single(1, 14'h0FFF);

        for (int j = 0; j < 3; j++) begin
            r = 14'($urandom);
            run_single(0, r);
        end
        for (int j = 0; j < 2; j++) begin
            r = 14'($urandom) & 14'h0FFF;
            run_single(1, r);
        end

        // Re-request and message change mid-frame are ignored.
        sel = 0;
        clear_logs();
        start_frame(0, 14'h2A5C, t0);
        repeat (9) @(negedge clk);
        #1;
        send_w[0] = 1'b1;
        msg_a = 14'($urandom);
        @(negedge clk); #1;
        send_w[0] = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        msg_a = ~msg_a;
        wait_done(1);
        repeat (120) @(negedge clk);
        #1;
        check_frame(0, 14'h2A5C, t0, 0);
        chk("single_done", done_t.size(), 1);
        chk("single_frame_pp", pp_t.size(), 3);

        // Asynchronous reset during chunk 1 strobe.
        clear_logs();
        start_frame(0, 14'($urandom), t0);
        repeat (18) @(negedge clk);
        #1;
        chk("pre_rst_pp_high", pp_w[0], 1);
        rst_n = 1'b0;
        #1;
        chk("arst_dout", dout_w[0], 0);
        chk("arst_pp", pp_w[0], 0);
        chk("arst_tc", tc_w[0], 0);
        chk("arst_busy", busy_w[0], 0);
        chk("arst_done", done_w[0], 0);
        repeat (3) @(negedge clk);
        #1;
        chk("arst_no_commit", tcr_t.size(), 0);
        chk("arst_no_publish", pub_q.size(), 0);
        clear_logs();
        rst_n = 1'b1;
        start_frame(0, 14'h0001, t0);
        wait_done(1);
        repeat (4) @(negedge clk);
        #1;
        check_frame(0, 14'h0001, t0, 0);

        // send held high: back-to-back frames, second accepted in the done cycle.
        sel = 2;
        clear_logs();
        msg_c = 14'h1234;
        send_w[2] = 1'b1;
        t0 = cyc + 1;
        @(negedge clk); #1;
        msg_c = 14'h3FFF;
        wait_done(1);
        @(negedge clk); #1;
        send_w[2] = 1'b0;
        wait_done(2);
        repeat (30) @(negedge clk);
        #1;
        check_frame(2, 14'h1234, t0, 0);
        check_frame(2, 14'h3FFF, t0 + 23, 1);
        chk("b2b_done_count", done_t.size(), 2);
        chk("b2b_dout_stable", unstable, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/async_oneway_transmitter.md
# async_oneway_transmitter

Sending end of the one-way asynchronous board-to-board link. It accepts a MSG_W-bit message from local game logic and serialises it into 6-bit chunks on `dout`. Each chunk is qualified by a rising edge on `packet_pulse`, and the whole message is published by a rising edge on `transmit_ctrl`. Every level is held long enough to pass the far end's debouncers.

## Interface
Parameters:
- MSG_W, default MESSAGE_SIZE (from constants.svh): message width in bits.
- HOLD_CYCLES, default 16: clk_send cycles each line level is held. Must be ≥2 and must exceed the receiver debounce latency.
- N_CHUNKS, localparam = MSG_W/6 + 1 (integer division): chunks per frame.

Ports:
- clk_send, input, 1: sole clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- send, input, 1: start request, sampled in IDLE only.
- message, input, MSG_W: payload, latched on accept.
- busy, output, 1: high from the cycle after accept until return to IDLE.
- done, output, 1: one-cycle pulse on return to IDLE after a complete frame.
- dout, output, 6: chunk data to the link.
- packet_pulse, output, 1: chunk strobe; the receiver shifts on its rising edge.
- transmit_ctrl, output, 1: commit strobe; the receiver publishes on its rising edge.

## Operation
- Frame: `{ (6*N_CHUNKS-MSG_W)'b0, message }`, split LSB-first. Chunk k = frame[6k+5:6k], with chunk 0 sent first.
  - The receiver shifts new chunks in at its MSB end. After N_CHUNKS chunks, its window [MSG_W+5 : MSG_W%6] holds message in its low MSG_W bits. This holds for every MSG_W, including MSG_W%6==0, where the final chunk is all-zero padding.
- All outputs are registered. No output is driven combinationally from inputs.
- State machine states: IDLE, SETUP, STROBE, RELEASE, COMMIT, COOLDOWN. A cycle counter `cnt` and a chunk index `idx` (width $clog2(N_CHUNKS+1)) track progress.
  - IDLE: all link lines low, busy=0.
    - send=1 → latch message into the shift register, idx=0, cnt=0, go to SETUP.
  - SETUP: dout=chunk idx, packet_pulse=0. After HOLD_CYCLES cycles → STROBE.
  - STROBE: packet_pulse=1, dout unchanged. After HOLD_CYCLES cycles → RELEASE.
  - RELEASE: packet_pulse=0, dout unchanged. After HOLD_CYCLES cycles:
    - idx==N_CHUNKS-1 → COMMIT.
    - otherwise idx+1, shift register >>6, → SETUP.
  - COMMIT: transmit_ctrl=1, dout held at the last chunk. After HOLD_CYCLES cycles → COOLDOWN.
  - COOLDOWN: transmit_ctrl=0. After HOLD_CYCLES cycles → IDLE, dout=0, done=1 for one cycle.
- dout changes only on SETUP entry, never while packet_pulse or transmit_ctrl is high.
- send while busy is ignored, and no request is queued.
- message changes after accept have no effect on the frame in flight.
- send held high continuously produces back-to-back frames. The next frame is accepted in the IDLE cycle that carries done=1.

## Timing
- Reset values: dout=0, packet_pulse=0, transmit_ctrl=0, busy=0, done=0, state=IDLE, cnt=0, idx=0.
- Accept at clock edge t0, where send=1 in IDLE. At t0 busy rises, dout=chunk 0, state=SETUP.
- packet_pulse rise for chunk k: t0 + HOLD_CYCLES*(3k+1).
- transmit_ctrl rise: t0 + 3*N_CHUNKS*HOLD_CYCLES.
- transmit_ctrl fall: t0 + (3*N_CHUNKS+1)*HOLD_CYCLES.
- busy fall and done pulse: t0 + (3*N_CHUNKS+2)*HOLD_CYCLES.
- Each strobe high time is exactly HOLD_CYCLES. The gap between strobe fall and the next strobe rise is exactly 2*HOLD_CYCLES.
- Reset asserted mid-frame: all outputs drop to reset values immediately, asynchronously.
  - No transmit_ctrl edge is produced, so the receiver's published buffer stays unchanged.
  - Stale partial chunks are overwritten by the next full frame.
- Reset released: the first accept is possible on the first clk_send edge with rst_n=1.

## Test plan
- MSG_W=14, HOLD_CYCLES=4, message=14'h2A5C, single send pulse.
  - Required: chunks 6'h1C, 6'h29, 6'h02 on dout.
  - packet_pulse rises at t0+4, t0+16, t0+28; transmit_ctrl rises at t0+36; done at t0+44; busy high for exactly 44 cycles.
- MSG_W=12, HOLD_CYCLES=4, message=12'hFFF.
  - Required: N_CHUNKS=3, chunks 6'h3F, 6'h3F, 6'h00.
  - A loopback receiver model reading [17:0] low 12 bits yields 12'hFFF.
- send pulsed again at t0+10 and message changed mid-frame during a 14-bit frame.
  - Required: the frame is identical to the first scenario, and exactly one done pulse occurs.
- rst_n driven low at t0+18, during chunk 1 STROBE.
  - Required: all outputs 0 without waiting for a clock edge, and no transmit_ctrl rise.
  - A subsequent frame of 14'h0001 is received correctly by the loopback model.
- send held high, HOLD_CYCLES=2, messages 14'h1234 then 14'h3FFF.
  - Required: the second accept occurs in the done cycle.
  - The loopback receiver publishes 14'h1234, then 14'h3FFF.
  - dout is stable across every packet_pulse high window.
